// File: rtl/hamm_serial_rx.sv
// SECDED Hamming(12,8)+P serial receiver: deframes, corrects/flags, queues decoded bytes in a FIFO.
// Latency: stop bit at cycle N -> out_valid in N+1 when empty; out_ready backpressure, overrun drop when full.

module hamm_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  assign rd_vld = (cnt != '0);
  assign do_rd  = rd_vld & rd_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
  assign wr_rdy = (cnt != FULL_CNT) | do_rd;
  assign do_wr  = wr_vld & wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module hamm_serial_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             clr_cnt,
  output logic [7:0]       out,
  output logic [3:0]       out_synd,
  output logic             single_err,
  output logic             double_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);
  typedef struct packed {
    logic [3:0] synd;
    logic       sgl;
    logic       dbl;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]  state;
  logic [3:0]  bitcnt;
  logic [11:0] h;
  logic        p;
  logic [3:0]  synd;
  logic        pe;
  logic [11:0] hc;
  rx_entry_t   dec;
  rx_entry_t   head;
  logic        frame_done;
  logic        push_rdy;
  logic        accept;

  // Masks select Hamming positions whose index has bit k set (bit i-1 holds position i).
  always_comb begin
    dec  = '0;
    synd = {^(h & 12'hF80), ^(h & 12'h878), ^(h & 12'h666), ^(h & 12'h555)};
    pe   = p ^ (^h);
    dec.sgl = pe && (synd <= 4'd12);
    dec.dbl = (pe && (synd > 4'd12)) || (!pe && (synd != 4'd0));
    hc = h;
    if (dec.sgl && (synd != 4'd0)) hc = h ^ (12'd1 << (synd - 4'd1));
    dec.synd = synd;
    dec.data = {hc[11], hc[10], hc[9], hc[8], hc[6], hc[5], hc[4], hc[2]};
  end

  assign frame_done = ser_valid & ser_in & (state == S_STOP);
  assign accept     = frame_done & push_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      h         <= '0;
      p         <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ser_valid & ~ser_in & (state == S_STOP);
      overrun   <= frame_done & ~push_rdy;
      if (ser_valid) begin
        case (state)
          S_IDLE: if (!ser_in) begin
            state  <= S_DATA;
            bitcnt <= '0;
          end
          S_DATA: if (bitcnt == 4'd12) begin
            p     <= ser_in;
            state <= S_STOP;
          end else begin
            h[bitcnt] <= ser_in;
            bitcnt    <= bitcnt + 4'd1;
          end
          // A bad stop bit returns to hunting; it is not itself treated as a start bit.
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (clr_cnt) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (accept && dec.sgl && (sec_cnt != CNT_MAX)) sec_cnt <= sec_cnt + CNT_W'(1);
      if (accept && dec.dbl && (ded_cnt != CNT_MAX)) ded_cnt <= ded_cnt + CNT_W'(1);
    end
  end

  hamm_rx_fifo #(
    .W     ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (frame_done),
    .wr_dat (dec),
    .wr_rdy (push_rdy),
    .rd_vld (out_valid),
    .rd_dat (head),
    .rd_rdy (out_ready)
  );

  assign out        = head.data;
  assign out_synd   = head.synd;
  assign single_err = head.sgl;
  assign double_err = head.dbl;
endmodule
